// File: rtl/pc_flag_unit.sv
// PC, N/Z/V flag register and halt state for the single-cycle control path.
// Optional retired/taken performance counters enabled by PC_PERF_CNT_EN.
module pc_flag_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pc_write,
    input  logic             branch,
    input  logic             br_reg,
    input  logic [8:0]       imm9,
    input  logic [15:0]      reg_target,
    input  logic             set_n,
    input  logic             set_z,
    input  logic             set_v,
    input  logic [15:0]      alu_result,
    input  logic             alu_ovfl,
    output logic [15:0]      pc_out,
    output logic [15:0]      pc_plus2,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             halt
`ifdef PC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        n_q, n_d;
    logic        z_q, z_d;
    logic        v_q, v_d;
    logic        retire;
    logic [15:0] br_off;

    assign retire   = (state_q == RUN) && !stall;
    assign pc_plus2 = pc_q + 16'd2;
    assign br_off   = {{6{imm9[8]}}, imm9, 1'b0};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        if (retire) begin
            if (!pc_write) begin
                // HLT: PC stays on the HLT address, flags untouched
                state_d = HALTED;
            end else begin
                if (br_reg)
                    pc_d = {reg_target[15:1], 1'b0};
                else if (branch)
                    pc_d = pc_plus2 + br_off;
                else
                    pc_d = pc_plus2;
                if (set_n) n_d = alu_result[15];
                if (set_z) z_d = (alu_result == 16'd0);
                if (set_v) v_d = alu_ovfl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
        end
    end

    assign pc_out = pc_q;
    assign n      = n_q;
    assign z      = z_q;
    assign v      = v_q;
    assign halt   = (state_q == HALTED);

`ifdef PC_PERF_CNT_EN
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] tkn_q, tkn_d;
    logic             taken;

    // pc_write gates branch/br_reg so HLT's don't-care outputs never count
    assign taken = retire && pc_write && (branch || br_reg);

    always_comb begin
        ret_d = ret_q;
        tkn_d = tkn_q;
        if (retire && (ret_q != '1))
            ret_d = ret_q + 1'b1;
        if (taken && (tkn_q != '1))
            tkn_d = tkn_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q <= '0;
            tkn_q <= '0;
        end else begin
            ret_q <= ret_d;
            tkn_q <= tkn_d;
        end
    end

    assign retired_cnt = ret_q;
    assign taken_cnt   = tkn_q;
`endif

endmodule

// File: tb/tb_pc_flag_unit.sv
// Self-checking bench for pc_flag_unit: directed vector table, hand sequences
// and randomized stimulus against an arithmetic reference model.
module tb_pc_flag_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          CW     = 4;

    logic        clk = 1'b0;
    logic        rst, stall, pc_write, branch, br_reg;
    logic [8:0]  imm9;
    logic [15:0] reg_target, alu_result;
    logic        set_n, set_z, set_v, alu_ovfl;
    logic [15:0] pc_out, pc_plus2;
    logic        dut_n, dut_z, dut_v, halt;
`ifdef PC_PERF_CNT_EN
    logic [CW-1:0] retired_cnt, taken_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pc_flag_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pc_write   (pc_write),
        .branch     (branch),
        .br_reg     (br_reg),
        .imm9       (imm9),
        .reg_target (reg_target),
        .set_n      (set_n),
        .set_z      (set_z),
        .set_v      (set_v),
        .alu_result (alu_result),
        .alu_ovfl   (alu_ovfl),
        .pc_out     (pc_out),
        .pc_plus2   (pc_plus2),
        .n          (dut_n),
        .z          (dut_z),
        .v          (dut_v),
        .halt       (halt)
`ifdef PC_PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt),
        .taken_cnt  (taken_cnt)
`endif
    );

    typedef struct {
        logic        stall;
        logic        pw;
        logic        br;
        logic        brr;
        logic [8:0]  imm;
        logic [15:0] tgt;
        logic        sn, sz, sv;
        logic [15:0] res;
        logic        ov;
        logic [15:0] e_pc;
        logic        e_n, e_z, e_v, e_h;
    } vec_t;

    vec_t vt[21];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic pw, input logic br,
                         input logic brr, input logic [8:0] im,
                         input logic [15:0] tg, input logic sn,
                         input logic sz, input logic sv,
                         input logic [15:0] rs, input logic ov);
        stall = s; pc_write = pw; branch = br; br_reg = brr;
        imm9 = im; reg_target = tg; set_n = sn; set_z = sz; set_v = sv;
        alu_result = rs; alu_ovfl = ov;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] epc,
                             input logic en, input logic ez,
                             input logic ev, input logic eh);
        chk({tag, ".pc"}, pc_out, epc);
        chk({tag, ".pc2"}, pc_plus2, epc + 16'd2);
        chk({tag, ".n"}, {15'd0, dut_n}, {15'd0, en});
        chk({tag, ".z"}, {15'd0, dut_z}, {15'd0, ez});
        chk({tag, ".v"}, {15'd0, dut_v}, {15'd0, ev});
        chk({tag, ".halt"}, {15'd0, halt}, {15'd0, eh});
    endtask

    // reference model state
    int m_pc;
    bit m_n, m_z, m_v, m_h;
    int m_ret, m_tkn;

    function automatic int sext9(input logic [8:0] x);
        return x[8] ? int'(x) - 512 : int'(x);
    endfunction

    task automatic model_step();
        int cmax;
        cmax = (1 << CW) - 1;
        if (rst) begin
            m_pc = int'(RST_PC); m_n = 0; m_z = 0; m_v = 0; m_h = 0;
            m_ret = 0; m_tkn = 0;
        end else if (!m_h && !stall) begin
            m_ret = (m_ret < cmax) ? m_ret + 1 : cmax;
            if (!pc_write) begin
                m_h = 1;
            end else begin
                if (branch || br_reg)
                    m_tkn = (m_tkn < cmax) ? m_tkn + 1 : cmax;
                if (br_reg)
                    m_pc = int'(reg_target) / 2 * 2;
                else if (branch)
                    m_pc = (m_pc + 2 + 2 * sext9(imm9)) & 32'hFFFF;
                else
                    m_pc = (m_pc + 2) & 32'hFFFF;
                if (set_n) m_n = alu_result[15];
                if (set_z) m_z = (alu_result == 16'd0);
                if (set_v) m_v = alu_ovfl;
            end
        end
    endtask

    initial begin
        //        st pw br brr imm     tgt       sn sz sv res       ov  e_pc      n  z  v  h
        vt[0]  = '{0, 1, 0, 0, 9'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 0, 0, 9'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0004, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 0, 9'h000, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0006, 0, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 1, 9'h000, 16'h0011, 0, 0, 0, 16'h0000, 0, 16'h0010, 0, 0, 0, 0};
        vt[4]  = '{0, 1, 1, 0, 9'h1FC, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h000A, 0, 0, 0, 0};
        vt[5]  = '{0, 1, 0, 1, 9'h000, 16'hFFF1, 0, 0, 0, 16'h0000, 0, 16'hFFF0, 0, 0, 0, 0};
        vt[6]  = '{0, 1, 1, 0, 9'h0FF, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h01F0, 0, 0, 0, 0};
        vt[7]  = '{0, 1, 1, 1, 9'h005, 16'h1235, 0, 0, 0, 16'h0000, 0, 16'h1234, 0, 0, 0, 0};
        vt[8]  = '{0, 1, 0, 0, 9'h000, 16'h0000, 1, 1, 1, 16'h8000, 1, 16'h1236, 1, 0, 1, 0};
        vt[9]  = '{0, 1, 0, 0, 9'h000, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h1238, 1, 1, 1, 0};
        vt[10] = '{1, 1, 1, 0, 9'h010, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h1238, 1, 1, 1, 0};
        vt[11] = '{1, 1, 1, 0, 9'h010, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h1238, 1, 1, 1, 0};
        vt[12] = '{1, 1, 1, 0, 9'h010, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h1238, 1, 1, 1, 0};
        vt[13] = '{0, 1, 1, 0, 9'h010, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h125A, 0, 1, 1, 0};
        vt[14] = '{0, 1, 0, 1, 9'h000, 16'hFFFE, 0, 0, 0, 16'h0000, 0, 16'hFFFE, 0, 1, 1, 0};
        vt[15] = '{0, 1, 0, 0, 9'h000, 16'h0000, 0, 0, 1, 16'h0000, 0, 16'h0000, 0, 1, 0, 0};
        vt[16] = '{0, 1, 1, 0, 9'h100, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'hFE02, 0, 1, 0, 0};
        vt[17] = '{0, 1, 0, 1, 9'h000, 16'h0020, 0, 0, 0, 16'h0000, 0, 16'h0020, 0, 1, 0, 0};
        vt[18] = '{0, 0, 'x,'x, 9'h0AA, 16'h5555, 1, 1, 1, 16'h8000, 1, 16'h0020, 0, 1, 0, 1};
        vt[19] = '{0, 1, 1, 0, 9'h010, 16'h0000, 1, 1, 1, 16'h8000, 1, 16'h0020, 0, 1, 0, 1};
        vt[20] = '{1, 1, 0, 1, 9'h000, 16'h4444, 1, 1, 1, 16'h0000, 0, 16'h0020, 0, 1, 0, 1};

        rst = 1'b1;
        drive(0, 1, 0, 0, 9'h0, 16'h0, 0, 0, 0, 16'h0, 0);
        tick();
        tick();
        chk_state("reset", RST_PC, 0, 0, 0, 0);
`ifdef PC_PERF_CNT_EN
        chk("reset.ret", 16'(retired_cnt), 16'd0);
        chk("reset.tkn", 16'(taken_cnt), 16'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].stall, vt[i].pw, vt[i].br, vt[i].brr, vt[i].imm,
                  vt[i].tgt, vt[i].sn, vt[i].sz, vt[i].sv, vt[i].res,
                  vt[i].ov);
            tick();
            chk_state($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_n,
                      vt[i].e_z, vt[i].e_v, vt[i].e_h);
`ifdef PC_PERF_CNT_EN
            if (i == 17) begin
                chk("cnt.ret_sat", 16'(retired_cnt), 16'd15);
                chk("cnt.tkn", 16'(taken_cnt), 16'd9);
            end
`endif
        end
`ifdef PC_PERF_CNT_EN
        chk("halt.tkn_hold", 16'(taken_cnt), 16'd9);
`endif

        // reset while halted and stalled
        drive(1, 1, 1, 0, 9'h010, 16'h0, 1, 1, 1, 16'h8000, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("rst_halted", RST_PC, 0, 0, 0, 0);
`ifdef PC_PERF_CNT_EN
        chk("rst_halted.ret", 16'(retired_cnt), 16'd0);
`endif

        // reset mid-stall after some progress
        drive(0, 1, 0, 0, 9'h0, 16'h0, 1, 1, 1, 16'h8000, 1);
        tick();
        tick();
        chk_state("pre_stall", 16'h0004, 1, 0, 1, 0);
        stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("rst_stall", RST_PC, 0, 0, 0, 0);

        // randomized run against the model
        m_pc = int'(RST_PC); m_n = 0; m_z = 0; m_v = 0; m_h = 0;
        m_ret = 0; m_tkn = 0;
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            pc_write   = ($urandom_range(0, 39) != 0);
            branch     = 1'($urandom);
            br_reg     = ($urandom_range(0, 3) == 0);
            imm9       = 9'($urandom);
            reg_target = 16'($urandom);
            set_n      = 1'($urandom);
            set_z      = 1'($urandom);
            set_v      = 1'($urandom);
            alu_result = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            alu_ovfl   = 1'($urandom);
            model_step();
            tick();
            chk_state("rand", 16'(m_pc), m_n, m_z, m_v, m_h);
`ifdef PC_PERF_CNT_EN
            chk("rand.ret", 16'(retired_cnt), 16'(m_ret));
            chk("rand.tkn", 16'(taken_cnt), 16'(m_tkn));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
